// File: rtl/bin_to_bcd_seq.sv
// Sequential 27-bit binary to 8-digit packed BCD converter (double dabble, one bit per clock).
// Latency: 27 clocks from the start-sampling edge to bcd_out/done; back-to-back every 28 clocks.
// Backpressure: none; start is ignored while busy, so the requester must wait for done.
// Optional feature macro: BCD_OVERFLOW_SAT_EN (saturate bcd_out to 9999_9999 on overflow).
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [26:0] bin_in,
    output logic [31:0] bcd_out,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [26:0] MAX_DEC   = 27'd99_999_999;
    localparam logic [4:0]  NUM_ITERS = 5'd27;

    state_t      state;
    logic [26:0] shift_reg;
    logic [31:0] scratch;
    logic [4:0]  cnt;
    logic        ovf_flag;
    logic [31:0] scratch_adj;
    logic [31:0] scratch_next;

    // Add-3 correction on every digit >= 5, then shift in the next binary MSB.
    // Carry out of the top digit falls off, giving the value modulo 10^8.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < 8; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_next = {scratch_adj[30:0], shift_reg[26]};
    end

    // Control FSM with all outputs registered; bcd_out only moves on a completing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= 27'd0;
            scratch   <= 32'd0;
            cnt       <= 5'd0;
            ovf_flag  <= 1'b0;
            bcd_out   <= 32'h0000_0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= 32'd0;
                        cnt       <= NUM_ITERS;
                        ovf_flag  <= (bin_in > MAX_DEC);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    shift_reg <= {shift_reg[25:0], 1'b0};
                    cnt       <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf_flag;
`ifdef BCD_OVERFLOW_SAT_EN
                        bcd_out  <= ovf_flag ? 32'h9999_9999 : scratch_next;
`else
                        bcd_out  <= scratch_next;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, monitor pops on done.
// Checks result value, overflow, completion cycle, busy width, reset behaviour and ignored starts.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [26:0] bin_in = 27'd0;
    logic [31:0] bcd_out;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

`ifdef BCD_OVERFLOW_SAT_EN
    localparam logic [31:0] EXP_MAX27 = 32'h9999_9999;
    localparam logic [31:0] EXP_1E8   = 32'h9999_9999;
`else
    localparam logic [31:0] EXP_MAX27 = 32'h3421_7727;
    localparam logic [31:0] EXP_1E8   = 32'h0000_0000;
`endif

    bin_to_bcd_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .bcd_out  (bcd_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: on every done pulse, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (!reset && done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending conversion", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bcd_out", bcd_out, e.bcd);
                check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                check("done_cycle", cyc, e.cyc);
            end
        end
        prev_done <= done;
    end

    // Called at a falling edge: assert start for one cycle and record what should come back.
    task automatic issue(input logic [26:0] val, input logic [31:0] exp_bcd, input logic exp_ovf);
        exp_t e;
        start  = 1'b1;
        bin_in = val;
        e.bcd  = exp_bcd;
        e.ovf  = exp_ovf;
        e.cyc  = cyc + 28;
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 27'($urandom);
    endtask

    // Wait (bounded) until done is seen at a falling edge; report busy-high cycles seen.
    task automatic wait_done(output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (!done && n < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 40 cycles expected done pulse");
        end
    endtask

    initial begin
        int bc;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_bcd", bcd_out, 32'h0000_0000);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);

        // Zero input.
        issue(27'd0, 32'h0000_0000, 1'b0);
        wait_done(bc);
        @(negedge clk);

        // Mid-range value, with busy width check.
        issue(27'd12_345_678, 32'h1234_5678, 1'b0);
        wait_done(bc);
        check("busy_width", bc, 27);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_falls", {31'd0, done}, 32'd0);

        // Largest in-range value, then back-to-back start in the done cycle.
        issue(27'd99_999_999, 32'h9999_9999, 1'b0);
        wait_done(bc);
        issue(27'd1, 32'h0000_0001, 1'b0);
        wait_done(bc);
        @(negedge clk);

        // Out-of-range values.
        issue(27'd134_217_727, EXP_MAX27, 1'b1);
        wait_done(bc);
        @(negedge clk);
        issue(27'd100_000_000, EXP_1E8, 1'b1);
        wait_done(bc);
        @(negedge clk);
        issue(27'd5_000_000, 32'h0500_0000, 1'b0);
        wait_done(bc);
        @(negedge clk);

        // Start during a conversion must be ignored.
        issue(27'd42, 32'h0000_0042, 1'b0);
        repeat (9) @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd777;
        @(negedge clk);
        start  = 1'b0;
        wait_done(bc);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-conversion.
        issue(27'd12_345_678, 32'h1234_5678, 1'b0);
        wait_done(bc);
        @(negedge clk);
        issue(27'd87_654_321, 32'h8765_4321, 1'b0);
        repeat (10) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        void'(q.pop_back());
        check("arst_bcd", bcd_out, 32'h0000_0000);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_reset_bcd", bcd_out, 32'h0000_0000);
        issue(27'd5, 32'h0000_0005, 1'b0);
        wait_done(bc);
        repeat (5) @(negedge clk);

        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
